ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It is the consumer end of the ID/EX latch and accepts the WB/M/EX control groups, NPC, the two register read values, the sign-extended immediate and the rt/rd fields.
- It decodes the ALU operation, performs the ALU and branch-target computation, and selects the destination register.
- It registers all results into the EX/MEM pipeline latch, with stall and flush control, for the MEM stage.

Parameters:
- DW, 32, datapath width of NPC, operands, immediate and results.
- RW, 5, register-address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- stall  input  1  hold the EX/MEM latch contents
- flush  input  1  load a bubble into the EX/MEM latch
- valid_in  input  1  ID/EX holds a real instruction
- WB_in  input  2  [1]=RegWrite, [0]=MemtoReg
- M_in  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- exe_in  input  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
- NPC_in  input  DW  PC+4 of the instruction
- RD1_in  input  DW  rs value
- RD2_in  input  DW  rt value
- Sign_in  input  DW  sign-extended immediate; [5:0] is funct for R-type
- Instr_20_16_in  input  RW  rt field
- Instr_15_11_in  input  RW  rd field
- valid_out  output  1  EX/MEM holds a real instruction
- WB_out  output  2  registered WB group
- M_out  output  3  registered M group
- branch_target  output  DW  registered NPC_in + (Sign_in << 2), mod 2^DW
- zero  output  1  registered (alu_result == 0)
- alu_result  output  DW  registered ALU result
- RD2_out  output  DW  registered RD2_in (store data)
- dest_out  output  RW  registered destination register

Behaviour:
- Reset: asynchronous, active-high. While rst=1, every output is 0, including valid_out, WB_out, M_out, branch_target, zero, alu_result, RD2_out and dest_out. Reset mid-operation discards the latched instruction immediately, without waiting for a clock edge.
- Combinational front end:
  - operand B = exe_in[0] ? Sign_in : RD2_in.
  - ALU control from ALUOp:
    - 00 = ADD.
    - 01 = SUB.
    - 10 = decode funct Sign_in[5:0]: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
    - 11 = reserved, result 0.
    - An unlisted funct gives result 0.
  - ADD and SUB wrap modulo 2^DW; there is no overflow trap and no overflow flag.
  - SLT is a signed compare: result 1 if RD1 < B as two's complement, else 0, zero-extended to DW.
  - zero is computed from the final ALU result, so it is also 1 for the reserved and unknown cases.
  - Destination = exe_in[3] ? Instr_15_11_in : Instr_20_16_in.
  - The branch target adder runs every cycle, independent of ALUOp.
- EX/MEM latch update on the rising edge of clk, in priority order:
  1. flush=1: valid_out, WB_out and M_out go to 0. All data outputs (branch_target, zero, alu_result, RD2_out, dest_out) also go to 0. flush takes priority over stall.
  2. stall=1 with flush=0: all outputs hold their current values.
  3. Otherwise: load all computed values.
     - valid_out <= valid_in.
     - When valid_in=0, WB_out and M_out load 0 so a bubble can never write a register or memory. Data fields load normally in this case.
- Latency:
  - Exactly 1 cycle from the ID/EX inputs to the outputs, with no internal multi-cycle state.
  - Throughput is one instruction per cycle when stall=0.
- Simultaneous stall, flush and valid_in=0 give the flush result.
- Outputs change only on a clock edge or on reset; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle with the latch loaded -> all outputs 0 immediately. Deassert rst and hold inputs at 0 for one edge -> valid_out=0, zero=1.
- R-type ADD: exe_in=4'b1100, WB_in=2'b10, RD1=7, RD2=5, Sign_in[5:0]=100000, rd=3, rt=9, valid_in=1 -> next edge alu_result=12, zero=0, dest_out=3, WB_out=10.
- R-type SLT and SUB:
  - SLT with RD1=0xFFFFFFFF, RD2=1, funct 101010 -> alu_result=1.
  - SUB with RD1=RD2=0x1234, funct 100010 -> alu_result=0, zero=1.
- lw with sign-extension and branch target:
  - lw: exe_in=4'b0001, M_in=010, RD1=0x100, Sign_in=0xFFFFFFFC, rt=8 -> alu_result=0xFC, dest_out=8, M_out=010.
  - beq: NPC_in=0x40, Sign_in=3, exe_in=4'b0010 -> branch_target=0x4C.
- Stall and flush:
  - Load ADD result 12, then stall=1 for 3 cycles with new inputs -> outputs stay at 12 / dest 3.
  - Assert stall=1 and flush=1 together -> WB_out=0, M_out=0, valid_out=0, alu_result=0.
- Bubble and wrap: valid_in=0 with WB_in=10, M_in=001 -> WB_out=0, M_out=0. Separately, ADD with RD1=0xFFFFFFFF, B=1 -> alu_result=0, zero=1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch-target adder and destination select,
// registered into the EX/MEM latch with stall and flush control.
module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_in,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    M_in,
  input  logic [3:0]    exe_in,
  input  logic [DW-1:0] NPC_in,
  input  logic [DW-1:0] RD1_in,
  input  logic [DW-1:0] RD2_in,
  input  logic [DW-1:0] Sign_in,
  input  logic [RW-1:0] Instr_20_16_in,
  input  logic [RW-1:0] Instr_15_11_in,
  output logic          valid_out,
  output logic [1:0]    WB_out,
  output logic [2:0]    M_out,
  output logic [DW-1:0] branch_target,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] RD2_out,
  output logic [RW-1:0] dest_out
);

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_NONE
  } alu_op_e;

  alu_op_e       op;
  logic [DW-1:0] opb;
  logic [DW-1:0] alu;
  logic [DW-1:0] bt;
  logic [RW-1:0] dst;

  logic          valid_q, valid_d;
  logic [1:0]    wb_q, wb_d;
  logic [2:0]    m_q, m_d;
  logic [DW-1:0] bt_q, bt_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic [RW-1:0] dst_q, dst_d;

  assign opb = exe_in[0] ? Sign_in : RD2_in;
  assign dst = exe_in[3] ? Instr_15_11_in : Instr_20_16_in;
  assign bt  = NPC_in + (Sign_in << 2);

  // ALU control: ALUOp selects fixed op or funct decode
  always_comb begin
    op = OP_NONE;
    case (exe_in[2:1])
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (Sign_in[5:0])
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          default:   op = OP_NONE;
        endcase
      end
      default: op = OP_NONE;
    endcase
  end

  // ALU datapath; add/sub wrap, SLT is signed
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD: alu = RD1_in + opb;
      OP_SUB: alu = RD1_in - opb;
      OP_AND: alu = RD1_in & opb;
      OP_OR:  alu = RD1_in | opb;
      OP_SLT: alu = {{(DW-1){1'b0}},
                     $signed(RD1_in) < $signed(opb)};
      default: alu = '0;
    endcase
  end

  // EX/MEM next state: flush over stall over load
  always_comb begin
    valid_d = valid_q;
    wb_d    = wb_q;
    m_d     = m_q;
    bt_d    = bt_q;
    zero_d  = zero_q;
    alu_d   = alu_q;
    rd2_d   = rd2_q;
    dst_d   = dst_q;
    if (flush) begin
      valid_d = 1'b0;
      wb_d    = '0;
      m_d     = '0;
      bt_d    = '0;
      zero_d  = 1'b0;
      alu_d   = '0;
      rd2_d   = '0;
      dst_d   = '0;
    end else if (!stall) begin
      valid_d = valid_in;
      wb_d    = valid_in ? WB_in : 2'b00;
      m_d     = valid_in ? M_in : 3'b000;
      bt_d    = bt;
      zero_d  = (alu == '0);
      alu_d   = alu;
      rd2_d   = RD2_in;
      dst_d   = dst;
    end
  end

  // EX/MEM latch with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      m_q     <= '0;
      bt_q    <= '0;
      zero_q  <= 1'b0;
      alu_q   <= '0;
      rd2_q   <= '0;
      dst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      m_q     <= m_d;
      bt_q    <= bt_d;
      zero_q  <= zero_d;
      alu_q   <= alu_d;
      rd2_q   <= rd2_d;
      dst_q   <= dst_d;
    end
  end

  assign valid_out     = valid_q;
  assign WB_out        = wb_q;
  assign M_out         = m_q;
  assign branch_target = bt_q;
  assign zero          = zero_q;
  assign alu_result    = alu_q;
  assign RD2_out       = rd2_q;
  assign dest_out      = dst_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a queue of expected
// EX/MEM contents checked one cycle after each drive.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  WB_in = '0;
  logic [2:0]  M_in = '0;
  logic [3:0]  exe_in = '0;
  logic [31:0] NPC_in = '0;
  logic [31:0] RD1_in = '0;
  logic [31:0] RD2_in = '0;
  logic [31:0] Sign_in = '0;
  logic [4:0]  rt_in = '0;
  logic [4:0]  rd_in = '0;
  logic        valid_out;
  logic [1:0]  WB_out;
  logic [2:0]  M_out;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] RD2_out;
  logic [4:0]  dest_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] bt;
    logic        z;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } exp_t;

  exp_t sb[$];
  exp_t cur = '0;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .WB_in(WB_in), .M_in(M_in),
    .exe_in(exe_in), .NPC_in(NPC_in), .RD1_in(RD1_in),
    .RD2_in(RD2_in), .Sign_in(Sign_in),
    .Instr_20_16_in(rt_in), .Instr_15_11_in(rd_in),
    .valid_out(valid_out), .WB_out(WB_out), .M_out(M_out),
    .branch_target(branch_target), .zero(zero),
    .alu_result(alu_result), .RD2_out(RD2_out),
    .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [1:0] aop, input logic [31:0] a,
    input logic [31:0] b, input logic [5:0] fn);
    logic [31:0] r;
    r = 32'd0;
    if (aop == 2'b00) r = a + b;
    else if (aop == 2'b01) r = a - b;
    else if (aop == 2'b10) begin
      if (fn == 6'h20) r = a + b;
      else if (fn == 6'h22) r = a - b;
      else if (fn == 6'h24) r = a & b;
      else if (fn == 6'h25) r = a | b;
      else if (fn == 6'h2A)
        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end
    return r;
  endfunction

  function automatic exp_t ref_next(input exp_t c);
    exp_t n;
    logic [31:0] b;
    n = c;
    b = exe_in[0] ? Sign_in : RD2_in;
    if (flush) n = '0;
    else if (!stall) begin
      n.v   = valid_in;
      n.wb  = valid_in ? WB_in : 2'b00;
      n.m   = valid_in ? M_in : 3'b000;
      n.bt  = NPC_in + {Sign_in[29:0], 2'b00};
      n.alu = ref_alu(exe_in[2:1], RD1_in, b, Sign_in[5:0]);
      n.z   = (n.alu == 32'd0);
      n.rd2 = RD2_in;
      n.dst = exe_in[3] ? rd_in : rt_in;
    end
    return n;
  endfunction

  task automatic chk1(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s got empty-queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk1({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e.v});
    chk1({tag, ".wb"}, {30'd0, WB_out}, {30'd0, e.wb});
    chk1({tag, ".m"}, {29'd0, M_out}, {29'd0, e.m});
    chk1({tag, ".bt"}, branch_target, e.bt);
    chk1({tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
    chk1({tag, ".alu"}, alu_result, e.alu);
    chk1({tag, ".rd2"}, RD2_out, e.rd2);
    chk1({tag, ".dst"}, {27'd0, dest_out}, {27'd0, e.dst});
  endtask

  task automatic drive(input logic v, input logic [1:0] wb,
                       input logic [2:0] m, input logic [3:0] ex,
                       input logic [31:0] npc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] s,
                       input logic [4:0] rt, input logic [4:0] rd);
    valid_in = v; WB_in = wb; M_in = m; exe_in = ex;
    NPC_in = npc; RD1_in = a; RD2_in = b; Sign_in = s;
    rt_in = rt; rd_in = rd;
  endtask

  task automatic step(input string tag, input logic st,
                      input logic fl);
    stall = st;
    flush = fl;
    cur = ref_next(cur);
    sb.push_back(cur);
    @(posedge clk);
    #1;
    check_out(tag);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #2;
    cur = '0;
    sb.push_back(cur);
    check_out("rst_init");
    #10 rst = 1'b0;

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h10, 7, 5, 32'h20, 9, 3);
    step("load", 0, 0);
    #2 rst = 1'b1;
    #1;
    cur = '0;
    sb.push_back(cur);
    check_out("rst_mid");
    #1 rst = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_rst", 0, 0);
    chk1("after_rst.zero1", {31'd0, zero}, 32'd1);

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h10, 7, 5, 32'h20, 9, 3);
    step("add", 0, 0);
    chk1("add.res12", alu_result, 32'd12);

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h14,
          32'hFFFF_FFFF, 1, 32'h2A, 9, 4);
    step("slt", 0, 0);
    chk1("slt.res1", alu_result, 32'd1);

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h18,
          32'h1234, 32'h1234, 32'h22, 9, 5);
    step("sub", 0, 0);

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h1C,
          32'hF0F0, 32'h0FF0, 32'h24, 1, 6);
    step("and", 0, 0);
    drive(1, 2'b10, 3'b000, 4'b1100, 32'h1C,
          32'hF0F0, 32'h0FF0, 32'h25, 1, 6);
    step("or", 0, 0);
    drive(1, 2'b10, 3'b000, 4'b1100, 32'h1C,
          32'hF0F0, 32'h0FF0, 32'h3F, 1, 6);
    step("badfn", 0, 0);
    drive(1, 2'b10, 3'b000, 4'b0110, 32'h1C,
          32'hF0F0, 32'h0FF0, 32'h20, 1, 6);
    step("rsvd", 0, 0);

    drive(1, 2'b11, 3'b010, 4'b0001, 32'h20,
          32'h100, 32'hABCD, 32'hFFFF_FFFC, 8, 2);
    step("lw", 0, 0);
    chk1("lw.resFC", alu_result, 32'hFC);

    drive(1, 2'b00, 3'b100, 4'b0010, 32'h40, 9, 9, 3, 1, 2);
    step("beq", 0, 0);
    chk1("beq.bt4C", branch_target, 32'h4C);

    drive(1, 2'b10, 3'b000, 4'b1100, 32'h10, 7, 5, 32'h20, 9, 3);
    step("preload", 0, 0);
    drive(1, 2'b11, 3'b011, 4'b0001, 32'h80, 1, 2, 3, 4, 5);
    step("stall1", 1, 0);
    drive(1, 2'b01, 3'b101, 4'b1010, 32'h90, 6, 7, 8, 10, 11);
    step("stall2", 1, 0);
    step("stall3", 1, 0);
    chk1("stall.res12", alu_result, 32'd12);

    drive(0, 2'b10, 3'b001, 4'b1100, 32'h10, 7, 5, 32'h20, 9, 3);
    step("stall_flush", 1, 1);

    drive(0, 2'b10, 3'b001, 4'b1100, 32'h10, 7, 5, 32'h20, 9, 3);
    step("bubble", 0, 0);

    drive(1, 2'b10, 3'b000, 4'b0000, 32'h50,
          32'hFFFF_FFFF, 1, 32'h20, 2, 7);
    step("wrap", 0, 0);
    chk1("wrap.zero1", {31'd0, zero}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 2'($urandom), 3'($urandom),
            4'($urandom), $urandom, $urandom, $urandom,
            {$urandom_range(0, 3) == 0 ? 26'd0 : 26'($urandom),
             6'($urandom_range(32, 42))},
            5'($urandom), 5'($urandom));
      step("rand", 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
